dot_feeder_14: RTL and testbench
================================

Name: dot_feeder_14

Overview:
- Sequencer on the driving side of the dot-channel interface.
- Accepts 36-element input windows from upstream over a valid/ready handshake.
- Walks the (phase, cs) weight schedule and drives ws_load, dc_load, cs, phase and d into one dot channel.
- Waits for the channel's valid, captures its q, and forwards each result downstream under backpressure; signals done when the schedule is exhausted.

Parameters:
- NUM_CS, 9, number of cs slots per phase (1..16).
- NUM_PHASE, 4, number of phases per run (1..8).
- TIMEOUT, 15, max cycles in LOAD without ch_valid before flagging error (1..255).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a run from IDLE; ignored otherwise.
- in_valid  input  1  upstream window available.
- in_ready  output  1  feeder accepts a window this cycle.
- in_d  input  36*`data_len  upstream window (element k at bits [k*`data_len +: `data_len]).
- ch_ws_load  output  1  weight_store load to channel.
- ch_dc_load  output  1  inner-product load to channel.
- ch_cs  output  4  weight chip select.
- ch_phase  output  3  weight phase.
- ch_d  output  36*`data_len  registered window to channel.
- ch_valid  input  1  channel result valid.
- ch_q  input  `data_len  channel result.
- out_valid  output  1  result available downstream.
- out_ready  input  1  downstream accepts.
- out_q  output  `data_len  captured result.
- busy  output  1  high from start until return to IDLE.
- done  output  1  one-cycle pulse after the last result handshakes.
- error  output  1  sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cs/phase counters=0; timeout counter=0. Every output is 0, including ch_d, out_q, error.
- State IDLE:
  - start=1 → FETCH; cs=0, phase=0, error=0, busy=1.
- State FETCH:
  - in_ready=1; ch loads held 0.
  - On in_valid&&in_ready: latch in_d into ch_d → LOAD.
- State LOAD:
  - ch_ws_load=1, ch_dc_load=1; ch_cs/ch_phase = counters; ch_d held stable; timeout counter increments each cycle.
  - On ch_valid=1: capture ch_q into out_q → EMIT.
  - Counter reaches TIMEOUT without ch_valid: error=1, loads drop, → IDLE, busy=0, no done pulse.
  - Loads assert in the cycle after the handshake.
  - The channel needs ≥3 cycles of concurrent load+ws_valid, so minimum LOAD dwell is 3 cycles.
- State EMIT:
  - Loads = 0, which clears the channel's internal count; EMIT therefore always lasts ≥1 cycle before the next LOAD.
  - out_valid=1; out_q stable until out_valid&&out_ready.
  - On handshake: advance cs (wrap NUM_CS-1→0, then phase+1).
  - If cs==NUM_CS-1 and phase==NUM_PHASE-1 → IDLE, done=1 for one cycle, busy=0; else → FETCH.
- ch_valid outside LOAD is ignored.
- start while busy is ignored.
- in_valid outside FETCH is not consumed.
- ch_cs and ch_phase change only in EMIT→FETCH and are held through LOAD.
- Widths: ch_cs counter 4 bits, ch_phase counter 3 bits, timeout counter 8 bits; no arithmetic on data.
- Result count per run = NUM_CS*NUM_PHASE, in order: phase outer, cs inner.
- Reset mid-run aborts immediately to the reset state; the channel sees loads drop to 0.

Decomposition:
- `data_len comes from num_data.v.
- Shared package/include (dot_feeder_defs.v): state encodings IDLE/FETCH/LOAD/EMIT (2 bits), CS_W=4, PHASE_W=3.
- One natural sub-module: sched_counter_14, the cs/phase nested wrap counter with a last flag.
- The FSM, window register and result register stay in the top level.

Test Plan:
- Nominal run with NUM_CS=2, NUM_PHASE=2, `data_len=16:
  - Stimulus: channel model raises ch_valid 3 cycles after loads rise with q=0x0010,0x0011,0x0012,0x0013; out_ready=1.
  - Required: out_q sequence matches in order with (phase,cs)=(0,0),(0,1),(1,0),(1,1); done pulses once; busy falls same cycle.
- Backpressure: out_ready=0 for 5 cycles in the first EMIT → out_valid and out_q=0x0010 held; loads stay 0; no FETCH until the handshake.
- Upstream stall: in_valid low for 4 cycles in FETCH → in_ready stays 1; loads stay 0; ch_d unchanged until the handshake; the latched window equals the in_d pattern 0x0001..0x0024.
- Timeout with TIMEOUT=15: ch_valid never asserted → exactly 15 LOAD cycles, then error=1, busy=0, no done; the next start clears error.
- Reset mid-LOAD: rst_n pulled low asynchronously → all outputs 0 within the same cycle; after release, start runs from (0,0).
- Spurious inputs: start while busy, and ch_valid in FETCH/EMIT → no state change and no extra results.

Source files
------------

// File: rtl/dot_feeder_14_pkg.sv
// Shared definitions for the dot-channel feeder: field widths, data width
// default and the sequencer state encoding.
package dot_feeder_14_pkg;

    localparam int CS_W         = 4;
    localparam int PHASE_W      = 3;
    localparam int TMO_W        = 8;
    localparam int NUM_ELEM     = 36;
    localparam int DEF_DATA_LEN = 16;
    // The channel needs this many cycles of concurrent loads before its q is meaningful.
    localparam int MIN_DWELL    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/dot_feeder_14_sched.sv
// sched_counter_14: nested (phase, cs) schedule counter, cs inner, with a
// flag marking the final slot of the run.
module sched_counter_14
    import dot_feeder_14_pkg::*;
#(
    parameter int NUM_CS    = 9,
    parameter int NUM_PHASE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               adv,
    output logic [CS_W-1:0]    cs,
    output logic [PHASE_W-1:0] phase,
    output logic               last
);

    localparam logic [CS_W-1:0]    CS_MAX    = CS_W'(NUM_CS - 1);
    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(NUM_PHASE - 1);

    logic cs_wrap;
    logic phase_wrap;

    assign cs_wrap    = (cs == CS_MAX);
    assign phase_wrap = (phase == PHASE_MAX);
    assign last       = cs_wrap && phase_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs    <= '0;
            phase <= '0;
        end else if (clr) begin
            cs    <= '0;
            phase <= '0;
        end else if (adv) begin
            if (cs_wrap) begin
                cs    <= '0;
                phase <= phase_wrap ? '0 : phase + PHASE_W'(1);
            end else begin
                cs <= cs + CS_W'(1);
            end
        end
    end

endmodule

// File: rtl/dot_feeder_14.sv
// Driving-side sequencer for one dot channel: fetches windows, walks the
// (phase, cs) weight schedule and forwards each channel result downstream.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; done pulses here after a completed run
// ST_FETCH | in_ready high, waiting for an upstream window
// ST_LOAD  | loads high to the channel, waiting for ch_valid or timeout
// ST_EMIT  | loads low, result presented downstream until accepted
module dot_feeder_14
    import dot_feeder_14_pkg::*;
#(
    parameter int NUM_CS    = 9,
    parameter int NUM_PHASE = 4,
    parameter int TIMEOUT   = 15,
    parameter int DATA_LEN  = DEF_DATA_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_ELEM*DATA_LEN-1:0] in_d,
    output logic                         ch_ws_load,
    output logic                         ch_dc_load,
    output logic [CS_W-1:0]              ch_cs,
    output logic [PHASE_W-1:0]           ch_phase,
    output logic [NUM_ELEM*DATA_LEN-1:0] ch_d,
    input  logic                         ch_valid,
    input  logic [DATA_LEN-1:0]          ch_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_LEN-1:0]          out_q,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] DWELL_MIN = TMO_W'(MIN_DWELL - 1);

    state_t                         state_q;
    state_t                         state_d;
    logic [TMO_W-1:0]               tmo_q;
    logic [NUM_ELEM*DATA_LEN-1:0]   win_q;
    logic [DATA_LEN-1:0]            res_q;
    logic                           error_q;
    logic                           done_q;

    logic sched_clr;
    logic sched_adv;
    logic sched_last;
    logic run_start;
    logic in_hs;
    logic capture;
    logic tmo_hit;
    logic out_hs;

    sched_counter_14 #(
        .NUM_CS    (NUM_CS),
        .NUM_PHASE (NUM_PHASE)
    ) u_sched (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sched_clr),
        .adv   (sched_adv),
        .cs    (ch_cs),
        .phase (ch_phase),
        .last  (sched_last)
    );

    assign run_start = (state_q == ST_IDLE) && start;
    assign in_hs     = (state_q == ST_FETCH) && in_valid;
    // ch_valid earlier than the minimum dwell cannot be a real result.
    assign capture   = (state_q == ST_LOAD) && ch_valid && (tmo_q >= DWELL_MIN);
    assign tmo_hit   = (state_q == ST_LOAD) && !capture && (tmo_q == TMO_LAST);
    assign out_hs    = (state_q == ST_EMIT) && out_ready;

    assign sched_clr = run_start;
    assign sched_adv = out_hs;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run_start) state_d = ST_FETCH;
            ST_FETCH: if (in_hs) state_d = ST_LOAD;
            ST_LOAD: begin
                if (capture)      state_d = ST_EMIT;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_EMIT:  if (out_hs) state_d = sched_last ? ST_IDLE : ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 tmo_q <= '0;
        else if (state_q == ST_LOAD) tmo_q <= tmo_q + TMO_W'(1);
        else                        tmo_q <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     win_q <= '0;
        else if (in_hs) win_q <= in_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       res_q <= '0;
        else if (capture) res_q <= ch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= out_hs && sched_last;
            if (run_start)    error_q <= 1'b0;
            else if (tmo_hit) error_q <= 1'b1;
        end
    end

    assign in_ready   = (state_q == ST_FETCH);
    assign ch_ws_load = (state_q == ST_LOAD);
    assign ch_dc_load = (state_q == ST_LOAD);
    assign ch_d       = win_q;
    assign out_valid  = (state_q == ST_EMIT);
    assign out_q      = res_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_dot_feeder_14.sv
// Scoreboard bench for dot_feeder_14 with a small 2x2 schedule and a
// behavioural dot channel that answers four cycles into each LOAD.
module tb_dot_feeder_14;

    localparam int DL  = 16;
    localparam int NE  = 36;
    localparam int W   = NE * DL;
    localparam int NCS = 2;
    localparam int NPH = 2;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_d = '0;
    logic          ch_ws_load;
    logic          ch_dc_load;
    logic [3:0]    ch_cs;
    logic [2:0]    ch_phase;
    logic [W-1:0]  ch_d;
    logic          ch_valid;
    logic [DL-1:0] ch_q;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DL-1:0] out_q;
    logic          busy;
    logic          done;
    logic          error;

    logic          mv = 1'b0;
    logic          spur_v = 1'b0;
    logic          ch_en = 1'b1;
    logic [DL-1:0] q_base = '0;
    int            q_idx = 0;
    int            load_cnt = 0;

    typedef struct {
        logic [15:0] q;
        logic [3:0]  cs;
        logic [2:0]  ph;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int results = 0;
    int done_cnt = 0;

    dot_feeder_14 #(
        .NUM_CS    (NCS),
        .NUM_PHASE (NPH),
        .TIMEOUT   (TMO),
        .DATA_LEN  (DL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_d       (in_d),
        .ch_ws_load (ch_ws_load),
        .ch_dc_load (ch_dc_load),
        .ch_cs      (ch_cs),
        .ch_phase   (ch_phase),
        .ch_d       (ch_d),
        .ch_valid   (ch_valid),
        .ch_q       (ch_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    assign ch_valid = mv | spur_v;
    assign ch_q     = q_base + DL'(q_idx);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_win(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_win(input int base);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < NE; k++) w[k*DL +: DL] = DL'(base + k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel model: q becomes valid once loads have been high for four edges.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!busy)   q_idx = 0;
            else if (mv) q_idx++;
            if (ch_ws_load && ch_dc_load && ch_en) load_cnt++;
            else                                  load_cnt = 0;
            mv = (load_cnt >= 4);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got q=%0h with nothing expected", out_q);
            end else begin
                e = sb.pop_front();
                chk("out_q", 64'(out_q), 64'(e.q));
                chk("res_cs", 64'(ch_cs), 64'(e.cs));
                chk("res_phase", 64'(ch_phase), 64'(e.ph));
                results++;
            end
        end
        if (done) begin
            done_cnt++;
            chk("busy_at_done", 64'(busy), 64'd0);
        end
    end

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input logic [15:0] qb, input bit stress);
        logic [W-1:0] prev;
        q_base = qb;
        for (int p = 0; p < NPH; p++)
            for (int c = 0; c < NCS; c++)
                sb.push_back('{q: qb + 16'(p*NCS + c), cs: 4'(c), ph: 3'(p)});
        do_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("error_after_start", 64'(error), 64'd0);
        for (int i = 0; i < NCS*NPH; i++) begin
            wait_in_ready();
            if (stress && i == 0) begin
                prev = ch_d;
                in_d = mk_win(1);
                for (int c = 0; c < 4; c++) begin
                    spur_v = (c == 1);
                    start  = (c == 2);
                    tick();
                    chk("stall_in_ready", 64'(in_ready), 64'd1);
                    chk("stall_loads", 64'({ch_ws_load, ch_dc_load}), 64'd0);
                    chk_win("stall_ch_d", ch_d, prev);
                end
                spur_v = 1'b0;
                start  = 1'b0;
            end
            in_d = mk_win(1 + 64*i);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("loads_up", 64'({ch_ws_load, ch_dc_load}), 64'd3);
            chk_win("ch_d_latched", ch_d, mk_win(1 + 64*i));
            in_d = '0;
            tick();
            chk_win("ch_d_held", ch_d, mk_win(1 + 64*i));
            if (stress && i == 0) out_ready = 1'b0;
            wait_out_valid();
            if (stress && i == 0) begin
                for (int c = 0; c < 5; c++) begin
                    spur_v = (c == 1);
                    start  = (c == 3);
                    tick();
                    chk("bp_out_valid", 64'(out_valid), 64'd1);
                    chk("bp_out_q", 64'(out_q), 64'(qb));
                    chk("bp_loads", 64'({ch_ws_load, ch_dc_load}), 64'd0);
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                end
                spur_v = 1'b0;
                start  = 1'b0;
                out_ready = 1'b1;
            end
            tick();
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        tick();
        chk("done_drop", 64'(done), 64'd0);
    endtask

    initial begin : main
        int n;
        int done_before;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_loads", 64'({ch_ws_load, ch_dc_load}), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done_error", 64'({done, error}), 64'd0);
        chk("rst_cs_phase", 64'({ch_cs, ch_phase}), 64'd0);
        chk("rst_out_q", 64'(out_q), 64'd0);
        chk_win("rst_ch_d", ch_d, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run(16'h0010, 1'b1);

        // Timeout: the channel never answers.
        ch_en = 1'b0;
        done_before = done_cnt;
        do_start();
        wait_in_ready();
        in_d = mk_win(200);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (ch_ws_load && n < 100) begin n++; tick(); end
        chk("tmo_load_cycles", 64'(n), 64'd15);
        chk("tmo_error", 64'(error), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);
        chk("tmo_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("tmo_no_done", 64'(done_cnt), 64'(done_before));
        ch_en = 1'b1;
        do_start();
        chk("restart_clears_error", 64'(error), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);

        // Asynchronous reset in the middle of LOAD.
        wait_in_ready();
        in_d = mk_win(300);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_loads", 64'({ch_ws_load, ch_dc_load}), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_loads", 64'({ch_ws_load, ch_dc_load}), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_error", 64'(error), 64'd0);
        chk("mid_rst_out_q", 64'(out_q), 64'd0);
        chk("mid_rst_cs_phase", 64'({ch_cs, ch_phase}), 64'd0);
        chk_win("mid_rst_ch_d", ch_d, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run(16'h0020, 1'b0);

        repeat (3) tick();
        chk("result_count", 64'(results), 64'd8);
        chk("done_count", 64'(done_cnt), 64'd2);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
